// File: rtl/amp_stream_reader.sv
// Captures an eight-entry amplitude bank on start and streams it over a valid/ready port,
// reporting the largest-magnitude entry once the whole snapshot has been transferred.
module amp_stream_reader #(
    parameter int NUM_AMP = 8,
    parameter int AMP_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [AMP_W-1:0] i0,
    input  logic signed [AMP_W-1:0] i1,
    input  logic signed [AMP_W-1:0] i2,
    input  logic signed [AMP_W-1:0] i3,
    input  logic signed [AMP_W-1:0] i4,
    input  logic signed [AMP_W-1:0] i5,
    input  logic signed [AMP_W-1:0] i6,
    input  logic signed [AMP_W-1:0] i7,
    output logic                    busy,
    output logic                    s_valid,
    input  logic                    s_ready,
    output logic signed [AMP_W-1:0] s_data,
    output logic [2:0]              s_index,
    output logic                    s_last,
    output logic [2:0]              peak_index,
    output logic [AMP_W-1:0]        peak_mag,
    output logic                    peak_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [AMP_W-1:0] MAG_ONE  = {{(AMP_W-1){1'b0}}, 1'b1};
    localparam logic [AMP_W-1:0] MAG_ZERO = {AMP_W{1'b0}};
    localparam logic [2:0]       IDX_LAST = 3'd7;

    // Unsigned magnitude; the most negative value maps to 2^(AMP_W-1), which still fits.
    function automatic logic [AMP_W-1:0] abs_mag(input logic signed [AMP_W-1:0] a);
        logic [AMP_W-1:0] r;
        if (a[AMP_W-1]) begin
            r = (~a) + MAG_ONE;
        end else begin
            r = a;
        end
        return r;
    endfunction

    state_t                  state_r;
    logic signed [AMP_W-1:0] snap_r [NUM_AMP];
    logic [AMP_W-1:0]        run_mag_r;
    logic [2:0]              run_idx_r;

    logic [AMP_W-1:0]        word_mag_s;
    logic [AMP_W-1:0]        nxt_mag_s;
    logic [2:0]              nxt_idx_s;
    logic [2:0]              nxt_index_s;
    logic                    xfer_s;

    // Running-max update for the word currently on the port; ties keep the earlier index.
    always_comb begin
        word_mag_s  = abs_mag(s_data);
        nxt_index_s = s_index + 3'd1;
        xfer_s      = s_valid & s_ready;
        nxt_mag_s   = run_mag_r;
        nxt_idx_s   = run_idx_r;
        if (word_mag_s > run_mag_r) begin
            nxt_mag_s = word_mag_s;
            nxt_idx_s = s_index;
        end else begin
            nxt_mag_s = run_mag_r;
            nxt_idx_s = run_idx_r;
        end
    end

    // Control FSM with all port outputs held in registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            s_valid    <= 1'b0;
            s_data     <= {AMP_W{1'b0}};
            s_index    <= 3'd0;
            s_last     <= 1'b0;
            peak_index <= 3'd0;
            peak_mag   <= MAG_ZERO;
            peak_valid <= 1'b0;
            run_mag_r  <= MAG_ZERO;
            run_idx_r  <= 3'd0;
            for (int k = 0; k < NUM_AMP; k++) begin
                snap_r[k] <= {AMP_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        snap_r[0]  <= i0;
                        snap_r[1]  <= i1;
                        snap_r[2]  <= i2;
                        snap_r[3]  <= i3;
                        snap_r[4]  <= i4;
                        snap_r[5]  <= i5;
                        snap_r[6]  <= i6;
                        snap_r[7]  <= i7;
                        s_data     <= i0;
                        s_index    <= 3'd0;
                        s_last     <= 1'b0;
                        s_valid    <= 1'b1;
                        busy       <= 1'b1;
                        run_mag_r  <= MAG_ZERO;
                        run_idx_r  <= 3'd0;
                        peak_valid <= 1'b0;
                        state_r    <= ST_STREAM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (xfer_s) begin
                        run_mag_r <= nxt_mag_s;
                        run_idx_r <= nxt_idx_s;
                        if (s_last) begin
                            s_valid    <= 1'b0;
                            busy       <= 1'b0;
                            s_last     <= 1'b0;
                            peak_index <= nxt_idx_s;
                            peak_mag   <= nxt_mag_s;
                            peak_valid <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            s_index <= nxt_index_s;
                            s_data  <= snap_r[nxt_index_s];
                            s_last  <= (nxt_index_s == IDX_LAST);
                            state_r <= ST_STREAM;
                        end
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy       <= 1'b0;
                    s_valid    <= 1'b0;
                    s_last     <= 1'b0;
                    peak_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
